// File: rtl/spi_target_if.sv
// SPI pin bundle between an initiator (master) and the target peripheral (slave).
interface spi_target_if;
    logic sclk;
    logic csb;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output csb, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input csb, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_target.sv
// Oversampled SPI target: LSB-first word deserialiser/serialiser with a per-frame CRC
// over the received words.
module spi_target #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [31:0] CRC_POLY   = 32'h0000_002F,
    parameter logic [31:0] CRC_INIT   = 32'h0000_00FF,
    parameter logic [31:0] CRC_FINAL  = 32'h0000_00FF,
    parameter int unsigned CRC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    spi_target_if.slave           spi,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_abort,
    output logic [15:0]           rx_count,
    output logic [CRC_WIDTH-1:0]  crc
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {StIdle, StActive} state_e;

    state_e                state_q, state_d;
    logic [2:0]            sclk_sync_q, csb_sync_q;
    logic [1:0]            mosi_sync_q, sync_ok_q;
    logic                  armed_q, armed_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d, crc_out_q, crc_out_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [15:0]           rx_count_q, rx_count_d;
    logic                  miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic                  rx_valid_q, rx_valid_d, frame_start_q, frame_start_d;
    logic                  frame_end_q, frame_end_d, frame_abort_q, frame_abort_d;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_word;

    logic sclk_rise, sclk_fall, csb_rise, csb_fall, mosi_bit, sample_edge, shift_edge;

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign csb_rise    = csb_sync_q[1] & ~csb_sync_q[2];
    assign csb_fall    = ~csb_sync_q[1] & csb_sync_q[2];
    assign mosi_bit    = mosi_sync_q[1];
    assign sample_edge = (mode_q[1] == mode_q[0]) ? sclk_rise : sclk_fall;
    assign shift_edge  = (mode_q[1] == mode_q[0]) ? sclk_fall : sclk_rise;
    assign tx_word     = tx_valid ? tx_data : '0;

    // Non-reflected CRC, word fed MSB-first.
    function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c_in,
                                                      input logic [DATA_WIDTH-1:0] d);
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = c_in;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ CRC_POLY[CRC_WIDTH-1:0];
        end
        return c;
    endfunction

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q | (sync_ok_q[1] & csb_sync_q[1]);
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        crc_d         = crc_q;
        crc_out_d     = crc_out_q;
        rx_data_d     = rx_data_q;
        rx_count_d    = rx_count_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_abort_d = 1'b0;
        tx_load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // armed_q blocks a frame that was already running when rst released
                if (csb_fall && armed_q) begin
                    state_d       = StActive;
                    frame_start_d = 1'b1;
                    mode_d        = mode;
                    cnt_d         = '0;
                    rx_count_d    = '0;
                    crc_d         = CRC_INIT[CRC_WIDTH-1:0];
                    tx_load       = 1'b1;
                    tx_shift_d    = mode[0] ? tx_word : (tx_word >> 1);
                    miso_d        = tx_word[0];
                    miso_oe_d     = 1'b1;
                end
            end
            StActive: begin
                if (sample_edge) begin
                    rx_shift_d[cnt_q] = mosi_bit;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        if (rx_count_q != 16'hFFFF) rx_count_d = rx_count_q + 16'd1;
                        crc_d      = crc_step(crc_q, rx_shift_d);
                        tx_load    = 1'b1;
                        tx_shift_d = tx_word;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    miso_d     = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
                // End of frame sees the effect of a same-cycle sample edge
                if (csb_rise) begin
                    state_d       = StIdle;
                    frame_end_d   = 1'b1;
                    frame_abort_d = (cnt_d != '0);
                    crc_out_d     = crc_d ^ CRC_FINAL[CRC_WIDTH-1:0];
                    miso_d        = 1'b0;
                    miso_oe_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sclk_sync_q   <= '0;
            csb_sync_q    <= '1;
            mosi_sync_q   <= '0;
            sync_ok_q     <= '0;
            armed_q       <= 1'b0;
            mode_q        <= '0;
            cnt_q         <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            crc_q         <= '0;
            crc_out_q     <= '0;
            rx_data_q     <= '0;
            rx_count_q    <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= {sclk_sync_q[1:0], spi.sclk};
            csb_sync_q    <= {csb_sync_q[1:0], spi.csb};
            mosi_sync_q   <= {mosi_sync_q[0], spi.mosi};
            sync_ok_q     <= {sync_ok_q[0], 1'b1};
            armed_q       <= armed_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            crc_q         <= crc_d;
            crc_out_q     <= crc_out_d;
            rx_data_q     <= rx_data_d;
            rx_count_q    <= rx_count_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign spi.miso    = miso_q;
    assign spi.miso_oe = miso_oe_q;
    assign tx_ready    = tx_load & ~rst;
    assign tx_underrun = tx_load & ~tx_valid & ~rst;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_abort = frame_abort_q;
    assign rx_count    = rx_count_q;
    assign crc         = crc_out_q;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an LSB-first SPI initiator drives the pins and results are
// compared against hand-computed values.
module tb_spi_target;
    localparam time HALF = 50ns;

    logic       clk, rst;
    logic [1:0] mode;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, tx_underrun, rx_valid;
    logic       frame_start, frame_end, frame_abort;
    logic [15:0] rx_count;
    logic [7:0] crc;

    spi_target_if spi_bus();

    spi_target dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .spi         (spi_bus),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_abort (frame_abort),
        .rx_count    (rx_count),
        .crc         (crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int rxv_cnt = 0, fe_cnt = 0, fs_cnt = 0, txr_cnt = 0, und_cnt = 0;
    int b_rxv, b_fe, b_fs, b_txr, b_und;
    logic       last_abort = 1'b0;
    logic [7:0] last_crc = 8'h00;
    logic       oe_seen;

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rx_valid)    rxv_cnt <= rxv_cnt + 1;
        if (tx_ready)    txr_cnt <= txr_cnt + 1;
        if (tx_underrun) und_cnt <= und_cnt + 1;
        if (frame_start) fs_cnt  <= fs_cnt + 1;
        if (frame_end) begin
            fe_cnt     <= fe_cnt + 1;
            last_abort <= frame_abort;
            last_crc   <= crc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_rxv = rxv_cnt; b_fe = fe_cnt; b_fs = fs_cnt; b_txr = txr_cnt; b_und = und_cnt;
    endtask

    task automatic frame_open(input logic [1:0] m);
        spi_bus.sclk = m[1];
        spi_bus.mosi = 1'b0;
        #(4*HALF);
        spi_bus.csb = 1'b0;
        #(2*HALF);
        oe_seen = spi_bus.miso_oe;
    endtask

    task automatic frame_close();
        #(HALF);
        spi_bus.csb = 1'b1;
        #(4*HALF);
    endtask

    task automatic xfer_bit(input logic [1:0] m, input logic b, output logic got);
        if (!m[0]) begin
            spi_bus.mosi = b;
            #(HALF);
            spi_bus.sclk = ~spi_bus.sclk;
            got = spi_bus.miso;
            #(HALF);
            spi_bus.sclk = ~spi_bus.sclk;
        end else begin
            spi_bus.sclk = ~spi_bus.sclk;
            spi_bus.mosi = b;
            #(HALF);
            spi_bus.sclk = ~spi_bus.sclk;
            got = spi_bus.miso;
            #(HALF);
        end
    endtask

    task automatic send_word(input logic [1:0] m, input logic [7:0] w, output logic [7:0] r);
        logic bit_got;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(m, w[i], bit_got);
            r[i] = bit_got;
        end
    endtask

    logic [7:0] got_w, got_w2;
    logic       got_b;
    logic [7:0] mode_rx [4] = '{8'h81, 8'h7E, 8'hC3, 8'h18};
    logic [1:0] m;
    int         und_mid;

    initial begin
        rst = 1'b1; mode = 2'd0; tx_data = 8'h00; tx_valid = 1'b0;
        spi_bus.sclk = 1'b0; spi_bus.csb = 1'b1; spi_bus.mosi = 1'b0;
        #2;
        #100;
        rst = 1'b0;
        #50;

        check_val("rst_rx_data", 32'(rx_data), 32'h00);
        check_val("rst_rx_count", 32'(rx_count), 32'h0);
        check_val("rst_crc", 32'(crc), 32'h00);
        check_val("rst_miso_oe", 32'(spi_bus.miso_oe), 32'h0);
        check_val("rst_miso", 32'(spi_bus.miso), 32'h0);
        check_val("rst_pulses", 32'({rx_valid, frame_start, frame_end, tx_ready}), 32'h0);

        // Mode 3, one word A5 in, 3C out
        tx_data = 8'h3C; tx_valid = 1'b1; mode = 2'd3;
        snap();
        frame_open(2'd3);
        send_word(2'd3, 8'hA5, got_w);
        frame_close();
        check_val("m3_oe_active", 32'(oe_seen), 32'h1);
        check_val("m3_rx_valid_n", 32'(rxv_cnt - b_rxv), 32'd1);
        check_val("m3_rx_data", 32'(rx_data), 32'hA5);
        check_val("m3_rx_count", 32'(rx_count), 32'd1);
        check_val("m3_frame_end_n", 32'(fe_cnt - b_fe), 32'd1);
        check_val("m3_frame_start_n", 32'(fs_cnt - b_fs), 32'd1);
        check_val("m3_abort", 32'(last_abort), 32'h0);
        check_val("m3_crc", 32'(last_crc), 32'hBE);
        check_val("m3_miso", 32'(got_w), 32'h3C);
        check_val("m3_oe_after", 32'(spi_bus.miso_oe), 32'h0);

        // Every mode; mode input is flipped mid-frame and must be ignored
        for (int k = 0; k < 4; k++) begin
            m = 2'(k);
            mode = m;
            snap();
            frame_open(m);
            mode = ~m;
            send_word(m, mode_rx[k], got_w);
            frame_close();
            check_val($sformatf("mode%0d_miso", k), 32'(got_w), 32'h3C);
            check_val($sformatf("mode%0d_rx_data", k), 32'(rx_data), 32'(mode_rx[k]));
            check_val($sformatf("mode%0d_tx_ready_n", k), 32'(txr_cnt - b_txr), 32'd2);
        end

        // Nine-word CRC check frame "123456789"
        mode = 2'd0;
        snap();
        frame_open(2'd0);
        for (int i = 0; i < 9; i++) send_word(2'd0, 8'(8'h31 + i), got_w);
        frame_close();
        check_val("crc9_crc", 32'(last_crc), 32'hDF);
        check_val("crc9_rx_count", 32'(rx_count), 32'd9);
        check_val("crc9_rx_data", 32'(rx_data), 32'h39);
        check_val("crc9_abort", 32'(last_abort), 32'h0);
        check_val("crc9_crc_held", 32'(crc), 32'hDF);

        // Abort 5 bits into the second word
        mode = 2'd3;
        snap();
        frame_open(2'd3);
        send_word(2'd3, 8'h31, got_w);
        for (int i = 0; i < 5; i++) xfer_bit(2'd3, 1'b1, got_b);
        frame_close();
        check_val("abort_rx_valid_n", 32'(rxv_cnt - b_rxv), 32'd1);
        check_val("abort_rx_count", 32'(rx_count), 32'd1);
        check_val("abort_flag", 32'(last_abort), 32'h1);
        check_val("abort_crc", 32'(last_crc), 32'h4F);
        check_val("abort_rx_data", 32'(rx_data), 32'h31);

        // No tx data: zeros shifted, underrun at start and after word 1
        tx_valid = 1'b0; tx_data = 8'hFF; mode = 2'd1;
        snap();
        frame_open(2'd1);
        send_word(2'd1, 8'h96, got_w);
        for (int i = 0; i < 7; i++) begin
            xfer_bit(2'd1, 1'b0, got_b);
            got_w2[i] = got_b;
        end
        #(HALF);
        und_mid = und_cnt - b_und;
        xfer_bit(2'd1, 1'b1, got_b);
        got_w2[7] = got_b;
        frame_close();
        check_val("und_miso_w0", 32'(got_w), 32'h00);
        check_val("und_miso_w1", 32'(got_w2), 32'h00);
        check_val("und_pulses", 32'(und_mid), 32'd2);
        check_val("und_rx_data", 32'(rx_data), 32'h80);
        check_val("und_rx_count", 32'(rx_count), 32'd2);

        // Reset mid-word with csb held low: frame must be dropped
        tx_valid = 1'b1; tx_data = 8'h3C; mode = 2'd0;
        snap();
        frame_open(2'd0);
        for (int i = 0; i < 4; i++) xfer_bit(2'd0, 1'b1, got_b);
        rst = 1'b1;
        #(HALF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) xfer_bit(2'd0, 1'b1, got_b);
        frame_close();
        check_val("rstmid_rx_valid_n", 32'(rxv_cnt - b_rxv), 32'd0);
        check_val("rstmid_frame_end_n", 32'(fe_cnt - b_fe), 32'd0);
        check_val("rstmid_rx_count", 32'(rx_count), 32'd0);
        check_val("rstmid_crc", 32'(crc), 32'h00);

        snap();
        frame_open(2'd0);
        send_word(2'd0, 8'h5A, got_w);
        frame_close();
        check_val("post_rst_rx_data", 32'(rx_data), 32'h5A);
        check_val("post_rst_frame_end_n", 32'(fe_cnt - b_fe), 32'd1);
        check_val("post_rst_rx_count", 32'(rx_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- Synthesizable SPI peripheral (target) that terminates the SPI bus driven by the team's SPI initiator model: pins sclk, mosi and csb in, miso out.
- Oversamples the SPI pins on the system clock.
- Deserialises received words and serialises transmit words, both LSB-first.
- Runs a CRC over each frame's received words and reports it at frame end for the register/packet layer above.

Parameters:
- DATA_WIDTH, 8: bits per SPI word.
- CRC_POLY, 32'h0000_002F: CRC polynomial, normal form, low CRC_WIDTH bits used.
- CRC_INIT, 32'h0000_00FF: CRC seed loaded at frame start.
- CRC_FINAL, 32'h0000_00FF: XOR mask applied to the reported CRC.
- CRC_WIDTH, 8: CRC register width.

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  synchronous reset, active-high.
- mode  in  2  {CPOL,CPHA}; captured on the synchronised csb falling edge.
- sclk  in  1  SPI clock, asynchronous.
- csb  in  1  chip select, active-low, asynchronous.
- mosi  in  1  serial data in, asynchronous.
- miso  out  1  serial data out.
- miso_oe  out  1  miso output enable; high while the frame is active.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  one-cycle pulse: tx_data consumed at this cycle if tx_valid=1.
- tx_underrun  out  1  one-cycle pulse: a word was loaded while tx_valid=0.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- frame_start  out  1  one-cycle pulse on csb assertion.
- frame_end  out  1  one-cycle pulse on csb deassertion.
- frame_abort  out  1  qualifies frame_end: the frame ended mid-word.
- rx_count  out  16  complete words received in the current or last frame; saturates at 16'hFFFF.
- crc  out  CRC_WIDTH  frame CRC, valid with frame_end.

Behaviour:
- Synchronisation:
  - sclk, csb and mosi each pass through a 2-FF synchroniser, followed by one register for edge detection.
  - Internal edge events occur 3 clk after the pin edge.
- Reset values:
  - miso=0, miso_oe=0, rx_data=0, rx_count=0, crc=0.
  - All pulse outputs = 0.
  - FSM = IDLE; synchroniser csb stage = 1.
- FSM states:
  - IDLE: waiting for csb to fall.
  - ACTIVE: frame in progress.
  - Any state -> IDLE on rst.
- IDLE -> ACTIVE on synchronised csb falling edge. In that cycle:
  - pulse frame_start;
  - latch mode;
  - bit counter=0, rx_count=0, crc register=CRC_INIT;
  - load the tx shifter (tx_ready pulse, tx_underrun if tx_valid=0, in which case zeros are shifted);
  - miso_oe=1, miso=tx bit0.
- Edges in ACTIVE:
  - Sample edge is rising sclk when CPOL==CPHA, falling otherwise. The shift edge is the opposite edge.
  - CPHA=0: bit0 is presented at csb assertion; each shift edge advances miso to the next bit.
  - CPHA=1: the first shift edge presents bit0. A shift edge that lands exactly on a word boundary presents bit0 of the newly loaded word.
- On each sample edge:
  - the synchronised mosi enters the rx shifter at position bit counter (LSB first);
  - the bit counter increments.
- Word completion (bit counter reaches DATA_WIDTH):
  - rx_data updated and rx_valid pulsed in the cycle after the sample edge;
  - rx_count increments;
  - CRC updated with the word, processed MSB-first (bit DATA_WIDTH-1 down to 0): standard non-reflected CRC, poly CRC_POLY;
  - bit counter wraps to 0;
  - the next tx word is loaded with a tx_ready pulse, following the same tx_valid/underrun rule.
- ACTIVE -> IDLE on synchronised csb rising edge:
  - pulse frame_end;
  - frame_abort=1 if bit counter != 0 (the partial word is discarded: no rx_valid, no CRC update);
  - crc = crc register XOR CRC_FINAL, held until the next frame_end;
  - miso_oe=0, miso=0.
- Simultaneous events:
  - A sample edge and a csb rise in the same cycle: process the sample edge (and any resulting word completion) first, then end the frame.
  - Sclk edges in IDLE are ignored.
  - A mode change during ACTIVE has no effect.
- rst mid-frame:
  - All state returns to reset values and no frame_end is issued.
  - Once rst falls, a frame already in progress is ignored until csb rises and falls again.
- A tx word is always fully shifted, or truncated by csb rise; it is never re-sent.

Test Plan:
- Mode 3, 100 ns sclk, clk 10 ns, one word mosi=8'hA5 LSB-first -> rx_valid once, rx_data=8'hA5, rx_count=1, frame_end with frame_abort=0.
- Modes 0/1/2/3 each, tx_data=8'h3C held valid -> initiator samples 8'h3C LSB-first on miso; tx_ready pulses at frame start and after each word.
- Nine-word frame 8'h31..8'h39 -> crc=8'hDF (CRC-8/AUTOSAR check value) at frame_end, rx_count=9.
- csb raised after 5 bits of the second word -> one rx_valid, rx_count=1, frame_abort=1, crc covers the first word only.
- tx_valid=0 throughout a 2-word frame -> miso all zeros, two tx_underrun pulses, rx path unaffected.
- rst asserted mid-word and released while csb low -> no rx_valid and no frame_end; the next full csb frame with 8'h5A gives rx_data=8'h5A.
